// File: rtl/bootram_ctrl.sv
// Boot RAM bus controller: serves PicoRV32 native-bus accesses with one wait state
// and streams a byte-wide boot image into four byte lanes while the CPU is stalled.
module bootram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    resetn,
    // CPU native memory bus
    input  logic                    mem_s_valid,
    output logic                    mem_s_ready,
    input  logic [31:0]             mem_s_addr,
    input  logic [31:0]             mem_s_wdata,
    input  logic [3:0]              mem_s_wstrb,
    output logic [31:0]             mem_s_rdata,
    // image loader stream
    input  logic                    ld_start,
    input  logic [ADDR_WIDTH+2:0]   ld_len,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [7:0]              ld_data,
    output logic                    ld_busy,
    output logic                    ld_done,
    // byte-lane RAM pins
    output logic [ADDR_WIDTH-1:0]   ram_ad,
    output logic [31:0]             ram_din,
    output logic [3:0]              ram_ce,
    output logic                    ram_wre,
    input  logic [31:0]             ram_dout
);

    localparam int unsigned LenW = ADDR_WIDTH + 3;
    localparam int unsigned PtrW = ADDR_WIDTH + 2;
    // Total byte span of the four lanes; longer load requests are clipped to it.
    localparam logic [LenW-1:0] Span = LenW'(4) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StLoad,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] len_clamp;
    logic            last_byte;

    assign len_clamp = (ld_len > Span) ? Span : ld_len;
    assign last_byte = ({1'b0, ptr_q} == (len_q - LenW'(1)));

    // State, byte pointer and load length registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic and all outputs; lane strobes are gated by reset so the
    // RAM contents survive a reset asserted mid-access or mid-load.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        mem_s_ready = 1'b0;
        mem_s_rdata = '0;
        ld_ready    = 1'b0;
        ld_busy     = 1'b0;
        ld_done     = 1'b0;
        ram_ad      = '0;
        ram_din     = '0;
        ram_ce      = 4'h0;
        ram_wre     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ld_start) begin
                    len_d   = len_clamp;
                    ptr_d   = '0;
                    state_d = (len_clamp == '0) ? StDone : StLoad;
                end else if (mem_s_valid) begin
                    ram_ad = mem_s_addr[ADDR_WIDTH+1:2];
                    if (mem_s_wstrb == 4'h0) begin
                        ram_ce  = 4'hF;
                        ram_wre = 1'b0;
                    end else begin
                        ram_ce  = mem_s_wstrb;
                        ram_wre = 1'b1;
                        ram_din = mem_s_wdata;
                    end
                    state_d = StAck;
                end
            end
            StAck: begin
                mem_s_ready = 1'b1;
                mem_s_rdata = ram_dout;
                state_d     = StIdle;
            end
            StLoad: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (ld_valid) begin
                    ram_ad  = ptr_q[ADDR_WIDTH+1:2];
                    ram_ce  = 4'b0001 << ptr_q[1:0];
                    ram_wre = 1'b1;
                    ram_din = {4{ld_data}};
                    // Pointer holds at len-1 on the final byte; the next load clears it.
                    if (last_byte) begin
                        state_d = StDone;
                    end else begin
                        ptr_d = ptr_q + PtrW'(1);
                    end
                end
            end
            StDone: begin
                ld_done = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!resetn) begin
            ram_ce  = 4'h0;
            ram_wre = 1'b0;
        end
    end

endmodule

// File: doc/bootram_ctrl.md
# bootram_ctrl

Bus-side controller for the 8 KiB boot RAM built from four 2K×8 single-port byte lanes (lane n holds byte n of each 32-bit word). It serves the PicoRV32 native memory bus with fixed one-wait-state reads and writes. It also provides a byte-stream loader port that writes a new boot image into the lanes while the CPU is stalled. It sits between the SoC address decoder and the four lane instances, driving their `ad`, `din`, `ce` and `wre` pins.

## Interface
- `ADDR_WIDTH`, 11: word-address width of each lane. Byte span is 4·2^ADDR_WIDTH.
- `clk` in 1: system clock; all state on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `mem_s_valid` in 1: CPU request valid.
- `mem_s_ready` out 1: one-cycle completion strobe.
- `mem_s_addr` in 32: byte address; only bits [ADDR_WIDTH+1:2] are used.
- `mem_s_wdata` in 32: write data.
- `mem_s_wstrb` in 4: byte write enables; 0 = read.
- `mem_s_rdata` out 32: read data, valid while `mem_s_ready`=1.
- `ld_start` in 1: pulse; begins an image load.
- `ld_len` in ADDR_WIDTH+3: byte count, sampled on `ld_start`.
- `ld_valid` in 1 / `ld_ready` out 1: byte-stream handshake.
- `ld_data` in 8: image byte.
- `ld_busy` out 1: high while loading.
- `ld_done` out 1: one-cycle pulse at load end.
- `ram_ad` out ADDR_WIDTH: shared lane word address.
- `ram_din` out 32: lane write data; byte n goes to lane n.
- `ram_ce` out 4: per-lane clock enable.
- `ram_wre` out 1: shared write enable.
- `ram_dout` in 32: lane read data, one cycle after a `ce` read.

## Operation
- FSM states:
  - IDLE: ready for a new CPU request or load.
  - ACK: completion cycle for a CPU access.
  - LOAD: streaming image bytes into the lanes.
  - DONE: one-cycle load-complete state.
- IDLE:
  - `ld_start`=1 has priority over `mem_s_valid`. It latches `len = min(ld_len, 4·2^ADDR_WIDTH)` and clears `ptr`.
    - `len`=0 → DONE.
    - Otherwise → LOAD.
  - Else if `mem_s_valid`=1, the access is issued this cycle and the FSM goes to ACK:
    - `ram_ad = mem_s_addr[ADDR_WIDTH+1:2]`.
    - Read (wstrb=0): `ram_ce=4'hF`, `ram_wre=0`.
    - Write: `ram_ce=mem_s_wstrb`, `ram_wre=1`, `ram_din=mem_s_wdata`.
  - Else `ram_ce=0`.
- ACK:
  - `mem_s_ready=1`, `mem_s_rdata=ram_dout` (for writes the value is don't-care).
  - `ram_ce=0`.
  - Next state is IDLE unconditionally. A still-high `mem_s_valid` in IDLE is treated as a new request.
- LOAD:
  - `ld_ready=1`, `ld_busy=1`.
  - On `ld_valid & ld_ready`:
    - `ram_ad = ptr[ADDR_WIDTH+1:2]`, `ram_ce = onehot(ptr[1:0])`, `ram_wre=1`, `ram_din = {4{ld_data}}`.
    - `ptr` increments.
    - When `ptr == len-1` at acceptance → DONE.
  - `mem_s_valid` is ignored and `mem_s_ready` stays 0, so the CPU stalls.
  - `ld_start` is ignored.
- DONE: `ld_done=1` for one cycle, `ld_busy=0`, then → IDLE.
- Little-endian packing: byte k of the image lands in lane k mod 4, word k/4.
- `ld_valid` outside LOAD is ignored (`ld_ready`=0).

## Timing
- Reset (`resetn`=0 at a clock edge): next cycle the FSM is in IDLE with `ptr`=0 and `len`=0.
  - Outputs after reset: `mem_s_ready`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0.
  - While `resetn`=0, `ram_ce`=0 and `ram_wre`=0 combinationally.
  - Lane contents are not altered.
  - Reset mid-LOAD aborts the load with no `ld_done`; bytes already written stay.
- CPU read/write latency: `mem_s_ready` rises exactly 1 cycle after the cycle `mem_s_valid` is sampled in IDLE. Back-to-back throughput is 1 access per 2 cycles.
- Loader throughput: 1 byte per cycle when `ld_valid` is held high. `ld_done` asserts 1 cycle after the last byte is accepted.
- `ram_*` outputs are combinational from the FSM state and the current-cycle request, so a lane write happens at the same edge the handshake completes.
- `ptr` never exceeds `len-1`; there is no wrap within a load.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles while `mem_s_valid`=1 → `ram_ce`=0 and `mem_s_ready`=0 throughout. The first `mem_s_ready` comes 2 cycles after release.
- **CPU write/read:** write 0xDEADBEEF to 0x0000_0010 with wstrb=F, then write wstrb=4'b0010 data 0x0000_5500 → a read of 0x10 returns 0xDEAD55EF; each `mem_s_ready` comes 1 cycle after issue.
- **Load:** `ld_start`, `ld_len`=6, bytes 01..06 with one `ld_valid` gap → words 0/1 read back as 0x04030201 / 0x????0605. `ld_done` comes 1 cycle after the 6th byte, and `ld_busy` is high only during LOAD.
- **Simultaneous events:** `ld_start` and `mem_s_valid` in the same cycle → load wins and the CPU sees no `mem_s_ready` until after DONE. The CPU access then completes with a correct value.
- **Length edge cases:**
  - `ld_len`=0 → `ld_done` on the next cycle, no `ram_ce`.
  - `ld_len`=9000 → exactly 8192 bytes accepted; the last byte lands at lane 3 word 2047.
- **Abort:** assert `resetn`=0 after 3 of 8 loaded bytes → no `ld_done`, `ld_ready`=0, the first 3 bytes remain readable, and a new load starts at `ptr`=0.
